pc_next_sequencer: RTL
======================

// Module: pc_next_sequencer
// PURPOSE
//  Next-PC generator and write controller sitting directly upstream of the 16-bit PC
//  register component. Each cycle it selects the next PC: sequential +2, relative branch,
//  absolute jump, call, or return. It drives that value and the write strobe into the PC
//  register, whose output is fed back as pc_current.
//  It owns the reset-vector load sequence, a run/halt state machine and a small
//  return-address stack (RAS).
// PARAMETERS
//  RESET_VECTOR  16'h0000  address loaded into PC in the INIT cycle after reset
//  INC           16'd2     sequential increment, in bytes; instructions are 16-bit
//  RAS_DEPTH     4         return-address stack entries; power of 2, range 2..16
// PORTS
//  clock          in   1   rising-edge clock shared with the PC register
//  reset          in   1   synchronous, active-high
//  pc_current     in   16  PC register output, fed back
//  start          in   1   IDLE->RUN request; level, sampled at the clock edge
//  halt           in   1   RUN->HALT request
//  stall          in   1   hold PC this cycle; highest priority after reset
//  branch_taken   in   1   relative branch
//  branch_offset  in   16  signed two's-complement byte offset, added to pc_current
//  jump           in   1   absolute jump to jump_target
//  call           in   1   push pc_current+INC, then go to jump_target
//  ret            in   1   pop RAS top into PC
//  jump_target    in   16  absolute target for jump/call
//  pc_next        out  16  value presented to the PC register input
//  pc_write       out  1   PC register write enable
//  running        out  1   1 only in RUN
//  ras_overflow   out  1   sticky; cleared only by reset
//  ras_underflow  out  1   sticky; cleared only by reset
// BEHAVIOUR
//  - Clock and reset: one clock domain; reset is synchronous and active-high.
//  - Reset values: state=INIT; RAS pointer=0 and count=0 (entry contents don't care);
//    ras_overflow=0, ras_underflow=0, running=0.
//  - Output timing: pc_next and pc_write are combinational from state and inputs.
//    The PC register captures pc_next at the same edge that advances state, so a
//    redirect has zero bubble.
//  - INIT: pc_write=1, pc_next=RESET_VECTOR, all other inputs ignored; next state IDLE.
//  - IDLE: pc_write=0. If start=1, go to RUN. If start and halt are both 1, halt wins:
//    go to HALT.
//  - RUN: running=1. Per-cycle action priority:
//      reset > stall > ret > call > jump > branch_taken > increment.
//      stall:  pc_write=0; RAS unchanged; halt is still honoured.
//      ret:    pc_next=RAS top; pop.
//      call:   pc_next=jump_target; push pc_current+INC.
//      jump:   pc_next=jump_target.
//      branch: pc_next=pc_current+branch_offset.
//      else:   pc_next=pc_current+INC.
//      pc_write=1 for every action except stall.
//  - halt in RUN: the current cycle's action still completes (including pc_write);
//    the next state is HALT.
//  - HALT: pc_write=0, running=0. Only reset exits HALT.
//  - Arithmetic: all sums are 16-bit modulo; carry is discarded, so 16'hFFFE+2 wraps to
//    16'h0000. branch_offset is used as-is; no sign extension is needed.
//  - Boundaries:
//      call and ret asserted together: ret executes, call is ignored, no push.
//      push with RAS full: the oldest entry is overwritten (circular); ras_overflow<=1.
//      ret with RAS empty: pc_next=pc_current+INC, count stays 0, ras_underflow<=1.
//      stall together with call or ret: no push or pop.
//      reset in any state (including mid-call): next state is INIT, RAS cleared,
//      flags cleared.
//      Control inputs (branch_taken, jump, call, ret) in INIT, IDLE or HALT are ignored;
//      no RAS change.
// STRUCTURE
//  - Shared package pc_pkg: state encoding localparams
//    (ST_INIT=2'd0, ST_IDLE=2'd1, ST_RUN=2'd2, ST_HALT=2'd3), PC_W=16, INC default.
//  - One sub-module, pc_ras: RAS_DEPTH x 16 circular stack with push, pop, top, full,
//    empty, and synchronous reset.
//  - The top level holds the FSM, the next-PC mux and the sticky flags.
// TESTING
//  1. Reset for 2 cycles, then release -> cycle 1: pc_write=1, pc_next=16'h0000; then
//     IDLE with pc_write=0.
//  2. start, then 3 cycles with no controls, PC register in loop -> PC runs 0002, 0004,
//     0006; running=1.
//  3. PC=0010, branch_offset=16'hFFF8 -> PC=0008. PC=FFFE, increment -> PC=0000.
//  4. PC=0100, call with jump_target=0400, then ret -> PC=0400, then PC=0102.
//  5. 5 calls, RAS_DEPTH=4 -> ras_overflow=1; 4 rets return to the newest 4 addresses;
//     5th ret -> PC+2 and ras_underflow=1.
//  6. stall+call together -> no PC or RAS change. call+ret together -> ret only.
//     halt -> HALT with pc_write=0. Reset mid-run -> INIT and PC=RESET_VECTOR.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the next-PC sequencer slice: FSM encoding and PC width.
package pc_pkg;

  localparam int unsigned PC_W = 16;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [PC_W-1:0] INC_DEFAULT = 16'd2;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  // ptr is the next free slot; when full it also addresses the oldest entry
  assign top     = mem[ptr - PTR_W'(1)];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && !do_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (do_pop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end else if (do_push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[ptr] <= din;
  end

endmodule

// File: rtl/pc_next_sequencer.sv
// Next-PC select and write strobe for the PC register, with run/halt FSM and RAS.
module pc_next_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
  parameter logic [PC_W-1:0] INC          = INC_DEFAULT,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_current,
  input  logic            start,
  input  logic            halt,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] pc_next,
  output logic            pc_write,
  output logic            running,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_full;
  logic            ras_empty;
  logic            push;
  logic            pop;
  logic            ret_empty;

  assign pc_inc  = pc_current + INC;
  assign running = (state == ST_RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_IDLE;
      ST_IDLE: if (start) state_nxt = halt ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt) state_nxt = ST_HALT;
      default: state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    pc_next   = pc_current;
    pc_write  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ret_empty = 1'b0;
    case (state)
      ST_INIT: begin
        pc_next  = RESET_VECTOR;
        pc_write = 1'b1;
      end
      ST_RUN: begin
        if (!stall) begin
          pc_write = 1'b1;
          if (ret) begin
            // An empty-stack return falls through as a plain increment
            if (ras_empty) begin
              pc_next   = pc_inc;
              ret_empty = 1'b1;
            end else begin
              pc_next = ras_top;
              pop     = 1'b1;
            end
          end else if (call) begin
            pc_next = jump_target;
            push    = 1'b1;
          end else if (jump) begin
            pc_next = jump_target;
          end else if (branch_taken) begin
            pc_next = pc_current + branch_offset;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_INIT;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push && ras_full) ras_overflow <= 1'b1;
      if (ret_empty) ras_underflow <= 1'b1;
    end
  end

  pc_ras #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

endmodule
